demux_bit_scheduler: RTL and testbench
======================================

# demux_bit_scheduler

Sequencer that feeds the 1-to-8 demultiplexer (`DEMUX1_8`). It accepts one byte per valid/ready handshake and serialises it onto the demux data input `i`. It also steps the select lines `s2..s0` from channel 0 to channel 7, so bit k of the byte appears on demux output `d[k]`. A `strobe` marks each stable bit slot so downstream channel logic can sample it.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1: clock cycles each bit/select pair is held; legal range 1..255.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: upstream byte valid.
- `in_data` in 8: byte to distribute; bit k goes to channel k.
- `in_ready` out 1: scheduler can accept a byte.
- `flush` in 1: synchronous abort of the byte in progress.
- `i` out 1: demux data input.
- `s0` out 1: demux select bit 0 (LSB).
- `s1` out 1: demux select bit 1.
- `s2` out 1: demux select bit 2 (MSB).
- `strobe` out 1: high while a bit slot is being presented.
- `busy` out 1: a byte is in progress (state SHIFT or DONE).
- `done` out 1: one-cycle pulse after channel 7's slot completes.

## Operation
- States are IDLE, SHIFT and DONE.
- **IDLE**
  - `in_ready`=1; `i`=0; `s2..s0`=000; `strobe`=0.
  - A handshake (`in_valid`&`in_ready`) at an edge latches `in_data` into the shift register, clears channel count `ch` and hold count `hc`, and moves to SHIFT.
- **SHIFT**
  - `in_ready`=0; `strobe`=1.
  - `{s2,s1,s0}`=`ch`; `i`=`shreg[ch]`.
  - `in_data` is ignored; the byte is latched.
  - `hc` counts 0..HOLD_CYCLES-1. At the slot's last cycle, `hc` is cleared and `ch` increments.
  - When `ch`=7 and `hc`=HOLD_CYCLES-1, the next state is DONE.
- **DONE**
  - `done`=1 for exactly one cycle; `strobe`=0; `i`=0; select=000; `in_ready`=0.
  - Next state is IDLE.
- **flush**
  - `flush`=1 in SHIFT or DONE forces IDLE at the next edge. No `done` pulse is produced, including when the flush occurs in DONE.
  - `flush` in IDLE has priority over a handshake: `in_ready` is held 0 while `flush`=1.
- **Arithmetic and widths**
  - `ch` is 3 bits and never wraps inside a byte; the exit occurs at 7.
  - `hc` is `$clog2(HOLD_CYCLES)` bits, with a minimum of 1.
  - With HOLD_CYCLES=1, `hc` stays 0 and `ch` advances every cycle.
- **Reset (any time, including mid-byte)**
  - State returns to IDLE and the byte is discarded.
  - Outputs: `i`=0, `s0`=`s1`=`s2`=0, `strobe`=0, `busy`=0, `done`=0.
  - `in_ready` is 1 once `rst` is released.
- All outputs are registered or decoded from registered state only. There are no combinational paths from `in_valid`/`in_data` to any output. `flush` gates `in_ready` combinationally.

## Timing
- **Edge E (handshake):**
  - Cycle E+1: first slot, channel 0, `i`=`in_data[0]`.
  - Channel k occupies cycles E+1+k·H .. E+(k+1)·H, where H=HOLD_CYCLES.
  - `done` is high in cycle E+8H+1.
  - `in_ready` returns in cycle E+8H+2.
- Per-byte period is 8H+2 cycles; minimum 10 cycles at H=1.
- `i` and select change together at slot boundaries, so they never differ in phase.
- `busy` = (state ≠ IDLE).

## Structure
- Shared package `demux_pkg` holds:
  - `NUM_CH`=8 and `SEL_W`=3;
  - the state typedef `sched_state_t` {IDLE, SHIFT, DONE};
  - the hold-counter width function.
- One sub-module is natural: `bit_hold_timer`. It is parameterised by HOLD_CYCLES, takes `clk`/`rst`/`clear`/`en`, and outputs `last`.
- The FSM, channel counter and output decode stay in the top.

## Test plan
- **Reset mid-byte:** H=1, byte 0xA5, assert `rst` at slot 3 → next cycle `i`=0, select=000, `strobe`=0, `busy`=0; `in_ready`=1 after release; no `done`.
- **Basic byte:** H=1, byte 0xA5 accepted at edge E.
  - Cycles E+1..E+8: (sel,`i`) = (0,1) (1,0) (2,1) (3,0) (4,0) (5,1) (6,0) (7,1).
  - `done` at E+9; `in_ready` at E+10.
- **Hold stretching:** H=3, byte 0x80 → `i`=0 for 21 cycles on channels 0–6, then `i`=1 for 3 cycles with select=111. `done` at E+25.
- **Back-to-back:** `in_valid` held high with 0xFF then 0x01 → second handshake exactly 10 cycles after the first (H=1). `in_data` changes during SHIFT do not alter `i`.
- **Flush:** H=2, byte 0x3C, `flush` during channel 4 → IDLE next cycle, `strobe`=0, no `done`.
  - A simultaneous `in_valid` in that IDLE cycle with `flush` still high is not accepted.
- **Demux integration:** scheduler drives `DEMUX1_8`; the bench captures `d[k]` on `strobe` over 0x00, 0xFF, 0x5A and 0xC3 → the captured vector equals the input byte each time.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-8 demux bit scheduler: channel geometry,
// FSM state type and the hold-counter width helper.
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  // Hold counter needs $clog2(hold) bits, but never fewer than one.
  function automatic int hold_cnt_w(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/demux_bit_hold_timer.sv
// Counts the cycles of one bit slot; 'last' flags the final cycle of the slot
// so the parent can advance the channel on the same edge the count wraps.
module bit_hold_timer
  import demux_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int HC_W = hold_cnt_w(HOLD_CYCLES);
  localparam logic [HC_W-1:0] LAST_HC = HC_W'(HOLD_CYCLES - 1);

  logic [HC_W-1:0] hc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
    end else if (clear || (en && last)) begin
      hc <= '0;
    end else if (en) begin
      hc <= hc + 1'b1;
    end
  end

  assign last = (hc == LAST_HC);

endmodule

// File: rtl/demux_bit_scheduler.sv
// Serialises one byte per handshake onto the demux data input while stepping
// the select lines through channels 0..7, one slot of HOLD_CYCLES per bit.
module demux_bit_scheduler
  import demux_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       flush,
  output logic       i,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       strobe,
  output logic       busy,
  output logic       done,
  output logic [1:0] fsm_state
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready is high only in IDLE with flush low; in_data is ignored otherwise.

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  sched_state_t      state, next_state;
  logic [SEL_W-1:0]  ch;
  logic [NUM_CH-1:0] shreg;
  logic [SEL_W-1:0]  sel;
  logic              take;
  logic              slot_last;
  logic              timer_clear;
  logic              timer_en;

  assign take        = in_valid && in_ready;
  assign timer_en    = (state == SHIFT);
  assign timer_clear = (state != SHIFT);

  bit_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .en   (timer_en),
    .last (slot_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (take) next_state = SHIFT;
      end
      SHIFT: begin
        if (flush) begin
          next_state = IDLE;
        end else if ((ch == LAST_CH) && slot_last) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Channel stops at 7; the FSM leaves SHIFT on that slot's last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      ch    <= '0;
    end else if (take) begin
      shreg <= in_data;
      ch    <= '0;
    end else if ((state == SHIFT) && slot_last && (ch != LAST_CH)) begin
      ch <= ch + 1'b1;
    end
  end

  // done is masked by flush so an abort in DONE produces no pulse.
  always_comb begin
    in_ready = 1'b0;
    i        = 1'b0;
    sel      = '0;
    strobe   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  in_ready = !flush;
      SHIFT: begin
        strobe = 1'b1;
        sel    = ch;
        i      = shreg[ch];
      end
      DONE:    done = !flush;
      default: ;
    endcase
  end

  assign s0        = sel[0];
  assign s1        = sel[1];
  assign s2        = sel[2];
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_demux_bit_scheduler.sv
// Scoreboard bench: three schedulers (HOLD_CYCLES 1, 2, 3) each drive a
// behavioural 1-to-8 demux; expected slots are derived from the timing rules.
module tb_demux_bit_scheduler;
  import demux_pkg::*;

  localparam int N_INST = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       in_valid [N_INST];
  logic [7:0] in_data  [N_INST];
  logic       flush    [N_INST];
  logic       in_ready [N_INST];
  logic       i_o      [N_INST];
  logic       s0       [N_INST];
  logic       s1       [N_INST];
  logic       s2       [N_INST];
  logic       strobe   [N_INST];
  logic       busy     [N_INST];
  logic       done     [N_INST];
  logic [1:0] fsm_state[N_INST];
  logic [2:0] sel      [N_INST];
  logic [7:0] d        [N_INST];

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    demux_bit_scheduler #(.HOLD_CYCLES(g + 1)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_data  (in_data[g]),
      .in_ready (in_ready[g]),
      .flush    (flush[g]),
      .i        (i_o[g]),
      .s0       (s0[g]),
      .s1       (s1[g]),
      .s2       (s2[g]),
      .strobe   (strobe[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .fsm_state(fsm_state[g])
    );
    assign sel[g] = {s2[g], s1[g], s0[g]};
    // Reference DEMUX1_8: d[k] = i when select == k.
    assign d[g] = 8'(i_o[g]) << sel[g];
  end

  // ---------------- scoreboard ----------------
  // Entry: {cycle[31:0], done, sel[2:0], i}
  logic [36:0] exp_q [N_INST][$];
  logic [7:0]  byte_q[N_INST][$];
  logic [7:0]  cap   [N_INST];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [36:0] pack(input int c, input logic dn, input logic [2:0] s, input logic b);
    logic [31:0] cv;
    cv = c;
    return {cv, dn, s, b};
  endfunction

  function automatic int hold_of(input int n);
    return n + 1;
  endfunction

  // Bit k of a byte accepted at edge e shows on channel k for cycles
  // e+1+k*h .. e+(k+1)*h; done follows at e+8h+1.
  task automatic push_byte(input int n, input int e, input logic [7:0] b);
    int h;
    h = hold_of(n);
    for (int k = 0; k < 8; k++)
      for (int t = 0; t < h; t++)
        exp_q[n].push_back(pack(e + 1 + k * h + t, 1'b0, 3'(k), b[k]));
    exp_q[n].push_back(pack(e + 8 * h + 1, 1'b1, 3'd0, 1'b0));
    byte_q[n].push_back(b);
  endtask

  // Abort: keep only slots already due; a done due this cycle is cancelled.
  task automatic prune(input int n);
    logic [36:0] keep[$];
    int c;
    foreach (exp_q[n][j]) begin
      c = int'(exp_q[n][j][36:5]);
      if (c < cyc || (c == cyc && !exp_q[n][j][4])) keep.push_back(exp_q[n][j]);
    end
    exp_q[n] = keep;
    byte_q[n].delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [36:0] e;
    for (int n = 0; n < N_INST; n++) begin
      if (strobe[n] || done[n]) begin
        if (exp_q[n].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output inst%0d: got strobe=%0b done=%0b sel=%0d i=%0b, required none (cycle %0d)",
                   n, strobe[n], done[n], sel[n], i_o[n], cyc);
        end else begin
          e = exp_q[n].pop_front();
          check($sformatf("slot inst%0d", n), {27'd0, cyc, done[n], sel[n], i_o[n]}, {27'd0, e});
        end
        if (strobe[n]) cap[n][sel[n]] = d[n][sel[n]];
        if (done[n]) begin
          if (byte_q[n].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL demux_capture inst%0d: got done with no byte outstanding", n);
          end else begin
            check($sformatf("demux_capture inst%0d", n), cap[n], byte_q[n].pop_front());
          end
          cap[n] = '0;
        end
      end else begin
        check($sformatf("quiet_outputs inst%0d", n), {i_o[n], sel[n]}, 4'd0);
        cap[n] = '0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (in_ready[n]) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    checks++;
    errors++;
    $display("FAIL ready_timeout inst%0d: got in_ready=0 for 40 cycles, required 1", n);
  endtask

  // flush_off < 0: no flush; otherwise flush in cycle e+1+flush_off.
  task automatic send(input int n, input logic [7:0] b, input int flush_off, input bit linger);
    int h;
    int e;
    bit ok;
    h = hold_of(n);
    wait_ready(n, ok);
    if (!ok) return;
    in_data[n]  = b;
    in_valid[n] = 1'b1;
    e = cyc;
    push_byte(n, e, b);
    step();
    in_valid[n] = 1'b0;
    for (int t = 1; t <= 8 * h + 1; t++) begin
      in_data[n] = 8'($urandom);
      if (t - 1 == flush_off) begin
        flush[n] = 1'b1;
        prune(n);
        step();
        check("busy_after_flush", busy[n], 0);
        check("strobe_after_flush", strobe[n], 0);
        if (linger) begin
          check("in_ready_gated_by_flush", in_ready[n], 0);
          in_valid[n] = 1'b1;
          step();
          in_valid[n] = 1'b0;
          check("no_accept_under_flush", busy[n], 0);
        end
        flush[n] = 1'b0;
        return;
      end
      step();
    end
    check($sformatf("in_ready_return inst%0d", n), in_ready[n], 1);
  endtask

  task automatic back_to_back();
    int e1;
    bit ok;
    bit seen;
    wait_ready(0, ok);
    if (!ok) return;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hFF;
    e1 = cyc;
    push_byte(0, e1, 8'hFF);
    step();
    in_data[0] = 8'h01;
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      if (in_ready[0]) begin
        seen = 1'b1;
        check("b2b_spacing", 64'(cyc - e1), 64'd10);
        push_byte(0, cyc, 8'h01);
      end
      step();
    end
    if (!seen) check("b2b_second_handshake", 0, 1);
    in_valid[0] = 1'b0;
    repeat (11) step();
  endtask

  initial begin
    int e;
    bit ok;
    logic [7:0] b;
    logic [7:0] pats[4];
    pats = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
    for (int n = 0; n < N_INST; n++) begin
      in_valid[n] = 1'b0;
      in_data[n]  = 8'h00;
      flush[n]    = 1'b0;
      cap[n]      = 8'h00;
    end
    rst = 1'b1;
    step();
    step();
    for (int n = 0; n < N_INST; n++)
      check($sformatf("reset_outputs inst%0d", n),
            {i_o[n], sel[n], strobe[n], busy[n], done[n], fsm_state[n]}, {7'd0, 2'(IDLE)});
    rst = 1'b0;
    #1;
    for (int n = 0; n < N_INST; n++) check("in_ready_after_reset", in_ready[n], 1);

    // Reset in the middle of a byte (H=1, channel 3).
    wait_ready(0, ok);
    in_data[0]  = 8'hA5;
    in_valid[0] = 1'b1;
    e = cyc;
    push_byte(0, e, 8'hA5);
    step();
    in_valid[0] = 1'b0;
    while (cyc < e + 4) step();
    check("slot3_before_reset", sel[0], 3);
    rst = 1'b1;
    for (int n = 0; n < N_INST; n++) begin
      exp_q[n].delete();
      byte_q[n].delete();
    end
    #1;
    check("mid_byte_reset_outputs", {i_o[0], sel[0], strobe[0], busy[0], done[0]}, 7'd0);
    step();
    rst = 1'b0;
    #1;
    check("in_ready_after_mid_reset", in_ready[0], 1);
    repeat (12) step();

    send(0, 8'hA5, -1, 1'b0);
    send(2, 8'h80, -1, 1'b0);
    send(1, 8'h3C, 8, 1'b1);
    back_to_back();

    foreach (pats[p])
      for (int n = 0; n < N_INST; n++) send(n, pats[p], -1, 1'b0);

    repeat (12) begin
      for (int n = 0; n < N_INST; n++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 3) == 0) send(n, b, int'($urandom_range(0, 8 * hold_of(n))), 1'b0);
        else send(n, b, -1, 1'b0);
        repeat ($urandom_range(0, 2)) step();
      end
    end

    repeat (5) step();
    for (int n = 0; n < N_INST; n++)
      check($sformatf("leftover_expectations inst%0d", n), exp_q[n].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
